// File: rtl/qadd_pkg.sv
// Shared helpers for the lane-summing Q-format accumulator: width rules,
// a constant clog2 and the saturate/wrap reduction of the wide total.
package qadd_pkg;

  // Widest accumulator the saturation helper can handle.
  localparam int unsigned MaxW = 256;

  // Default geometry, matching the top-level parameter defaults.
  localparam int unsigned DefN     = 32;
  localparam int unsigned DefLanes = 4;
  localparam int unsigned DefGuard = 8;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    longint unsigned v;
    r = 0;
    v = 1;
    while (v < longint'(value)) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Lane-sum width and accumulator width for a given geometry.
  function automatic int unsigned sum_w(input int unsigned n, input int unsigned lanes);
    return n + clog2(lanes);
  endfunction

  function automatic int unsigned acc_w(input int unsigned n, input int unsigned lanes,
                                        input int unsigned guard);
    return sum_w(n, lanes) + guard;
  endfunction

  localparam int unsigned SUM_W = sum_w(DefN, DefLanes);
  localparam int unsigned ACC_W = acc_w(DefN, DefLanes, DefGuard);

  typedef struct packed {
    logic [MaxW-1:0] value;
    logic            ovf;
  } sat_res_t;

  // Reduce a sign-extended wide value to n bits. ovf flags any value outside
  // the n-bit signed range; the caller keeps value[n-1:0], which is either the
  // clamped bound (sat=1) or the plain truncation (sat=0).
  function automatic sat_res_t sat_trunc(input logic signed [MaxW-1:0] value,
                                         input int unsigned n, input logic sat);
    logic signed [MaxW-1:0] max_v;
    logic signed [MaxW-1:0] min_v;
    sat_res_t               r;
    max_v   = (MaxW'(1) << (n - 1)) - MaxW'(1);
    min_v   = ~max_v;
    r.ovf   = (value > max_v) || (value < min_v);
    r.value = value;
    if (r.ovf && sat) begin
      r.value = (value > max_v) ? max_v : min_v;
    end
    return r;
  endfunction

endpackage

// File: rtl/qadd_tree.sv
// Combinational signed adder tree: LANES operands of N bits summed into a
// result wide enough that no partial sum can overflow.
module qadd_tree
  import qadd_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned LANES = 4,
  localparam int unsigned SumW = N + clog2(LANES)
) (
  input  logic [LANES*N-1:0]   data_i,
  output logic signed [SumW-1:0] sum_o
);

  localparam int unsigned Levels = clog2(LANES);
  localparam int unsigned Pad    = 1 << Levels;

  logic signed [SumW-1:0] node [Pad];

  // Pairwise reduction; missing lanes of a non-power-of-two tree add zero.
  always_comb begin
    for (int k = 0; k < int'(Pad); k++) begin
      node[k] = '0;
    end
    for (int k = 0; k < int'(LANES); k++) begin
      node[k] = SumW'($signed(data_i[k*N +: N]));
    end
    for (int lvl = 0; lvl < int'(Levels); lvl++) begin
      for (int i = 0; i < int'(Pad >> (lvl + 1)); i++) begin
        node[i] = node[2*i] + node[2*i+1];
      end
    end
    sum_o = node[0];
  end

endmodule

// File: rtl/qadd_acc.sv
// Packet accumulator: each accepted beat adds its lane sum into a widened
// accumulator; the last beat (or the beat that hits MAXBEATS) produces one
// saturated or wrapped N-bit result behind a valid/ready output register.
module qadd_acc
  import qadd_pkg::*;
#(
  parameter int unsigned N        = DefN,
  parameter int unsigned Q        = 15,
  parameter int unsigned LANES    = DefLanes,
  parameter int unsigned GUARD    = DefGuard,
  parameter int unsigned MAXBEATS = 256,
  localparam int unsigned BeatW   = clog2(MAXBEATS + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [LANES*N-1:0] in_data_i,
  input  logic               in_last_i,
  input  logic               sat_en_i,
  input  logic               clear_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [N-1:0]       out_data_o,
  output logic               out_ovf_o,
  output logic [BeatW-1:0]   out_beats_o
);

  localparam int unsigned SumW = sum_w(N, LANES);
  localparam int unsigned AccW = acc_w(N, LANES, GUARD);

  // Q only documents the number format; a nonsensical geometry stops elaboration.
  if (AccW > MaxW || LANES < 1 || MAXBEATS < 1 || Q >= N) begin : g_bad_params
    $error("qadd_acc: unsupported parameter combination");
  end

  logic signed [AccW-1:0] acc_q, acc_d;
  logic [BeatW-1:0]       beat_cnt_q, beat_cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [N-1:0]           out_data_q, out_data_d;
  logic                   out_ovf_q, out_ovf_d;
  logic [BeatW-1:0]       out_beats_q, out_beats_d;

  logic signed [SumW-1:0] lane_sum;
  logic signed [AccW-1:0] total;
  logic                   accept;
  logic                   is_last;
  sat_res_t               res;
  logic                   unused_res_hi;

  qadd_tree #(
    .N     (N),
    .LANES (LANES)
  ) u_tree (
    .data_i (in_data_i),
    .sum_o  (lane_sum)
  );

  // The output slot frees up in the same cycle it is consumed; clear blocks intake.
  assign in_ready_o = (!out_valid_q || out_ready_i) && !clear_i;
  assign accept     = in_valid_i && in_ready_o;
  assign is_last    = in_last_i || (beat_cnt_q == BeatW'(MAXBEATS - 1));
  assign total      = acc_q + AccW'(lane_sum);

  assign res           = sat_trunc(MaxW'(total), N, sat_en_i);
  assign unused_res_hi = ^res.value[MaxW-1:N];

  // Accumulator and beat counter: restart after a last beat, abort on clear.
  always_comb begin
    acc_d      = acc_q;
    beat_cnt_d = beat_cnt_q;
    if (clear_i) begin
      acc_d      = '0;
      beat_cnt_d = '0;
    end else if (accept) begin
      if (is_last) begin
        acc_d      = '0;
        beat_cnt_d = '0;
      end else begin
        acc_d      = total;
        beat_cnt_d = beat_cnt_q + BeatW'(1);
      end
    end
  end

  // Output register: load on a last beat, otherwise drop valid on handshake and hold data.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_beats_d = out_beats_q;
    if (accept && is_last) begin
      out_valid_d = 1'b1;
      out_data_d  = res.value[N-1:0];
      out_ovf_d   = res.ovf;
      out_beats_d = beat_cnt_q + BeatW'(1);
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any partial packet and pending result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q       <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_beats_q <= '0;
    end else begin
      acc_q       <= acc_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_beats_q <= out_beats_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ovf_o   = out_ovf_q;
  assign out_beats_o = out_beats_q;

endmodule

// File: tb/tb_qadd_acc.sv
// Bench for qadd_acc: directed packets with literal results, then random
// traffic, all checked every cycle against an arithmetic packet model.
module tb_qadd_acc;

  localparam int N     = 16;
  localparam int Q     = 8;
  localparam int LANES = 4;
  localparam int GUARD = 8;
  localparam int MAXB  = 8;
  localparam int BW    = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, in_last, sat_en, clear;
  logic [LANES*N-1:0] in_data;
  logic              out_valid, out_ready, out_ovf;
  logic [N-1:0]      out_data;
  logic [BW-1:0]     out_beats;

  always #5 clk = ~clk;

  qadd_acc #(
    .N        (N),
    .Q        (Q),
    .LANES    (LANES),
    .GUARD    (GUARD),
    .MAXBEATS (MAXB)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .sat_en_i    (sat_en),
    .clear_i     (clear),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_ovf_o   (out_ovf),
    .out_beats_o (out_beats)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  // Packet model: running sum as a plain integer, pending result as a slot.
  longint     m_acc;
  int         m_cnt;
  bit         m_valid;
  logic [15:0] m_data;
  bit         m_ovf;
  int         m_beats;

  always @(negedge clk) begin
    bit     exp_ready, acc_ok, last;
    longint lsum, total;
    if (!rst_n) begin
      m_acc = 0; m_cnt = 0; m_valid = 0; m_data = '0; m_ovf = 0; m_beats = 0;
      chk("reset out_valid", 64'(out_valid), 64'(0));
      chk("reset out_data", 64'(out_data), 64'(0));
      chk("reset out_ovf", 64'(out_ovf), 64'(0));
      chk("reset out_beats", 64'(out_beats), 64'(0));
    end else begin
      exp_ready = (!m_valid || out_ready) && !clear;
      chk("in_ready", 64'(in_ready), 64'(exp_ready));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("out_data", 64'(out_data), 64'(m_data));
        chk("out_ovf", 64'(out_ovf), 64'(m_ovf));
        chk("out_beats", 64'(out_beats), 64'(m_beats));
      end
      acc_ok = in_valid && exp_ready;
      lsum = 0;
      for (int k = 0; k < LANES; k++) lsum += longint'($signed(in_data[k*N +: N]));
      total = m_acc + lsum;
      last  = in_last || (m_cnt == MAXB - 1);
      if (acc_ok && last) begin
        m_valid = 1;
        m_ovf   = (total > 32767) || (total < -32768);
        if (m_ovf && sat_en) m_data = (total > 0) ? 16'h7FFF : 16'h8000;
        else m_data = total[15:0];
        m_beats = m_cnt + 1;
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (clear) begin
        m_acc = 0; m_cnt = 0;
      end else if (acc_ok) begin
        if (last) begin m_acc = 0; m_cnt = 0; end
        else begin m_acc = total; m_cnt++; end
      end
    end
  end

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [63:0] d, input bit last, input bit sat);
    int w = 0;
    bit ok = 0;
    in_data = d; in_last = last; sat_en = sat; in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      w++;
    end while (!ok && w < 50);
    if (!ok) chk("send accept timeout", 64'(0), 64'(1));
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Wait (bounded) for a result handshake and compare against literals.
  task automatic expect_out(input string name, input logic [15:0] d, input bit o,
                            input int b);
    int w = 0;
    @(negedge clk);
    while (!(out_valid && out_ready) && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) chk({name, " result timeout"}, 64'(0), 64'(1));
    else begin
      chk({name, " data"}, 64'(out_data), 64'(d));
      chk({name, " ovf"}, 64'(out_ovf), 64'(o));
      chk({name, " beats"}, 64'(out_beats), 64'(b));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt;
    rst_n = 0; in_valid = 0; in_last = 0; sat_en = 1; clear = 0; out_ready = 1;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    // Mixed-sign single beat.
    send(pack4(16'h0100, 16'h0200, 16'hFF00, 16'h0080), 1, 1);
    expect_out("t1", 16'h0280, 0, 1);

    // Positive overflow, saturated then wrapped.
    for (int s = 1; s >= 0; s--) begin
      send(pack4(16'h4000, 16'h4000, 16'h4000, 16'h4000), 0, s[0]);
      send(pack4(16'h4000, 16'h4000, 16'h4000, 16'h4000), 0, s[0]);
      send(pack4(16'h4000, 16'h4000, 16'h4000, 16'h4000), 1, s[0]);
      expect_out(s ? "t2 sat" : "t2 wrap", s ? 16'h7FFF : 16'h0000, 1, 3);
    end

    // Negative overflow and exact minimum.
    send(pack4(16'h8000, 16'h8000, 16'h8000, 16'h8000), 0, 1);
    send(pack4(16'h8000, 16'h8000, 16'h8000, 16'h8000), 1, 1);
    expect_out("t3 negsat", 16'h8000, 1, 2);
    send(pack4(16'h8000, 16'h0000, 16'h0000, 16'h0000), 1, 1);
    expect_out("t3 min", 16'h8000, 0, 1);

    // Beat limit forces the end of a packet without in_last.
    for (int i = 0; i < MAXB; i++) send(pack4(16'd1, 16'd0, 16'd0, 16'd0), 0, 1);
    expect_out("beat limit", 16'd8, 0, MAXB);

    // Backpressure: pending result stalls intake and stays stable.
    out_ready = 0;
    send(pack4(16'd5, 16'd0, 16'd0, 16'd0), 1, 1);
    in_data = pack4(16'd7, 16'd0, 16'd0, 16'd0); in_last = 1; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4 stall in_ready", 64'(in_ready), 64'(0));
      chk("t4 held data", 64'(out_data), 64'(5));
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(negedge clk);
    chk("t4 release in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    expect_out("t4 second", 16'd7, 0, 1);

    // Back-to-back single-beat packets.
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      in_data = pack4(16'(i + 1), 16'(i), 16'd0, 16'd0); in_last = 1; in_valid = 1;
      @(negedge clk);
      if (i > 0) begin
        cnt += int'(out_valid);
        chk("t5 data", 64'(out_data), 64'(2 * i - 1));
      end
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0;
    @(negedge clk);
    cnt += int'(out_valid);
    chk("t5 last data", 64'(out_data), 64'(15));
    chk("t5 result count", 64'(cnt), 64'(8));
    @(posedge clk); #1;

    // clear mid-packet drops the partial sum and the beat presented with it.
    send(pack4(16'd3, 16'd3, 16'd3, 16'd3), 0, 1);
    send(pack4(16'd3, 16'd3, 16'd3, 16'd3), 0, 1);
    clear = 1; in_data = pack4(16'd9, 16'd9, 16'd9, 16'd9); in_last = 1; in_valid = 1;
    @(negedge clk);
    chk("t6 clear in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    clear = 0; in_valid = 0; in_last = 0;
    send(pack4(16'd1, 16'd1, 16'd1, 16'd1), 1, 1);
    expect_out("t6 after clear", 16'd4, 0, 1);

    // Reset mid-packet: no result, nothing carried over.
    send(pack4(16'd100, 16'd0, 16'd0, 16'd0), 0, 1);
    rst_n = 0;
    @(negedge clk);
    chk("t6 reset out_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    send(pack4(16'd2, 16'd0, 16'd0, 16'd0), 1, 1);
    expect_out("t6 after reset", 16'd2, 0, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = {$urandom, $urandom};
      in_last   = ($urandom % 4) == 0;
      sat_en    = $urandom % 2;
      clear     = ($urandom % 50) == 0;
      out_ready = ($urandom % 3) != 0;
      @(posedge clk); #1;
    end
    in_valid = 0; clear = 0; out_ready = 1; in_last = 0;
    repeat (4) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qadd_acc.md
Name: qadd_acc

Overview:
- Parametrised successor to the two-operand Q-format adder.
- Sums LANES signed fixed-point operands per beat through an adder tree, and accumulates beats into a widened accumulator until a beat marked last.
- Emits one N-bit result per packet, saturated or wrapped, with valid/ready handshakes on both sides.
- Sits after the multiplier array in the convolution datapath; one packet is one output pixel's partial products.

Parameters:
- N, 32, operand and result width (two's complement).
- Q, 15, fractional bits. Format is unchanged by addition; informational only; no shifting.
- LANES, 4, operands per input beat (>=1).
- GUARD, 8, extra accumulator bits beyond N+clog2(LANES).
- MAXBEATS, 256, maximum beats per packet; also sizes the beat counter.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, input beat accepted when in_valid & in_ready.
- in_data, in, LANES*N, lane k at bits [k*N+N-1 : k*N], signed.
- in_last, in, 1, final beat of packet.
- sat_en, in, 1, 1 = saturate result, 0 = wrap (truncate). Sampled with the last beat.
- clear, in, 1, synchronous abort: discards the partial accumulation.
- out_valid, out, 1, result valid.
- out_ready, in, 1, result consumed when out_valid & out_ready.
- out_data, out, N, packet result.
- out_ovf, out, 1, result exceeded N-bit signed range (set regardless of sat_en).
- out_beats, out, clog2(MAXBEATS+1), number of beats in the packet.

Behaviour:
- Widths:
  - SUM_W = N + clog2(LANES); ACC_W = SUM_W + GUARD.
  - All adds are sign-extended; the accumulator never wraps within MAXBEATS beats.
- Reset: acc=0, beat_cnt=0, out_valid=0, out_data=0, out_ovf=0, out_beats=0. in_ready=1 combinationally once out_valid=0.
- in_ready = !out_valid | out_ready. No combinational path from in_valid to in_ready.
- Accepted non-last beat: acc <= acc + lanesum; beat_cnt++.
- Accepted last beat:
  - total = acc + lanesum.
  - Next cycle: out_valid=1; out_data = sat/wrap(total); out_ovf = (total > 2^(N-1)-1) | (total < -2^(N-1)); out_beats = beat_cnt+1.
  - acc and beat_cnt return to 0 in the same edge.
  - Latency: last beat accepted at edge t -> out_valid high after edge t.
- Saturation: positive overflow -> 2^(N-1)-1; negative overflow -> -2^(N-1). Wrap takes total[N-1:0].
- Output hold: out_data, out_ovf and out_beats stay stable while out_valid & !out_ready.
  - out_valid drops on handshake unless a new last beat is accepted the same cycle; back-to-back results are then sustained.
- Back-to-back packets: the beat after a last beat starts from acc=0. Full throughput is one beat/cycle with no bubble.
- Beat limit: a beat with beat_cnt == MAXBEATS-1 is treated as last even when in_last=0.
- clear:
  - Forces acc=0 and beat_cnt=0. Any beat presented in the same cycle is dropped (in_ready=0 while clear=1).
  - Does not affect a pending output.
- Simultaneous output handshake and last-beat accept: the output registers take the new result; no loss.
- Reset mid-packet: all state is dropped; no result is produced.

Decomposition:
- Package qadd_pkg:
  - function sat_trunc(value, ACC_W -> N), with overflow flag.
  - function clog2.
  - localparams SUM_W and ACC_W.
- One sub-module, qadd_tree: parametrised combinational signed adder tree, LANES*N -> SUM_W. The accumulator, counter and handshake stay in qadd_acc.

Test Plan:
1. N=16, Q=8, LANES=4, sat_en=1. One beat {0x0100, 0x0200, 0xFF00, 0x0080} with last -> out_data=0x0280, out_ovf=0, out_beats=1, one cycle after accept.
2. Three beats of {0x4000 x4}, last on beat 3, sat_en=1 -> total 0x30000; out_data=0x7FFF, out_ovf=1, out_beats=3. Repeat with sat_en=0 -> out_data=0x0000, out_ovf=1.
3. Negative saturation: two beats of {0x8000 x4} -> out_data=0x8000, out_ovf=1. Single beat {0x8000, 0, 0, 0} -> out_data=0x8000, out_ovf=0.
4. Backpressure: out_ready=0 while a result is pending -> in_ready=0, next packet's beats are stalled, outputs stable. Release out_ready -> same-cycle accept; results arrive in order with no loss or duplication.
5. Back-to-back single-beat packets over 8 cycles with out_ready=1 -> 8 results on consecutive cycles; no accumulation carries across packets.
6. clear asserted mid-packet after 2 beats, then a 1-beat packet {1, 1, 1, 1} last -> out_data=4, out_beats=1. Separately, assert rst_n=0 mid-packet -> no output; all outputs return to 0.
